// File: rtl/video_out_pkg.sv
// Shared constants for the video output path: TMDS control codes and
// serializer defaults.
package video_out_pkg;

  // TMDS control symbols, indexed by {C1,C0}
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam int         SYM_W_DEF    = 10;
  localparam logic [9:0] IDLE_SYM_DEF = CTRL_00;

endpackage

// File: rtl/video_ser_lane.sv
// One serial lane: parallel-load shift register with a registered serial
// output. On load the first bit goes straight to the output flop so it
// appears in the cycle right after the load edge.
module video_ser_lane #(
  parameter int SYM_W     = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [SYM_W-1:0] sym,
  output logic             ser
);

  logic [SYM_W-1:0] sr;

  // Shift register and output flop; clear wins, then load, then shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      ser <= 1'b0;
    end else if (clear) begin
      sr  <= '0;
      ser <= 1'b0;
    end else if (load) begin
      if (LSB_FIRST != 0) begin
        ser <= sym[0];
        sr  <= {1'b0, sym[SYM_W-1:1]};
      end else begin
        ser <= sym[SYM_W-1];
        sr  <= {sym[SYM_W-2:0], 1'b0};
      end
    end else begin
      if (LSB_FIRST != 0) begin
        ser <= sr[0];
        sr  <= {1'b0, sr[SYM_W-1:1]};
      end else begin
        ser <= sr[SYM_W-1];
        sr  <= {sr[SYM_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/video_serializer.sv
// Bit-rate serializer for CHANNELS parallel symbol lanes with a one-entry
// holding buffer, clock-lane pattern, symbol-boundary strobe and idle
// insertion on underflow.
module video_serializer
  import video_out_pkg::*;
#(
  parameter int               CHANNELS  = 3,
  parameter int               SYM_W     = SYM_W_DEF,
  parameter int               LSB_FIRST = 1,
  parameter logic [SYM_W-1:0] IDLE_SYM  = IDLE_SYM_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic [CHANNELS*SYM_W-1:0] sym_i,
  input  logic                      sym_valid_i,
  output logic                      sym_ready_o,
  output logic [CHANNELS-1:0]       ser_o,
  output logic                      ser_clk_o,
  output logic                      frame_o,
  output logic                      underflow_o,
  output logic [15:0]               underflow_cnt_o,
  input  logic                      underflow_clr_i
);

  localparam int               CNT_W    = (SYM_W > 2) ? $clog2(SYM_W) : 1;
  localparam int               BUS_W    = CHANNELS * SYM_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SYM_W / 2);

  if ((SYM_W < 2) || ((SYM_W % 2) != 0)) begin : g_bad_sym_w
    $error("video_serializer: SYM_W must be even and >= 2");
  end

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             buf_full;
  logic [BUS_W-1:0] buf_data;
  logic [BUS_W-1:0] load_data;
  logic             load;
  logic             accept;
  logic             idle_ins;
  logic             lane_clear;
  logic             frame_q;
  logic             ser_clk_q;
  logic             underflow_q;
  logic [15:0]      uf_cnt_q;

  // Ready depends only on buffer state and the load slot, never on valid
  assign sym_ready_o     = !buf_full || load;
  assign lane_clear      = !en_i;
  assign frame_o         = frame_q;
  assign ser_clk_o       = ser_clk_q;
  assign underflow_o     = underflow_q;
  assign underflow_cnt_o = uf_cnt_q;

  // Load slot, handshake and the next bit index shown on the outputs
  always_comb begin
    load      = en_i && (bit_cnt == CNT_LAST);
    accept    = sym_valid_i && sym_ready_o;
    idle_ins  = load && !buf_full;
    load_data = buf_full ? buf_data : {CHANNELS{IDLE_SYM}};
    if (!en_i)
      bit_cnt_nxt = CNT_LAST;
    else if (bit_cnt == CNT_LAST)
      bit_cnt_nxt = '0;
    else
      bit_cnt_nxt = bit_cnt + 1'b1;
  end

  // Bit counter plus frame strobe and clock-lane pattern, aligned with ser_o
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt   <= CNT_LAST;
      frame_q   <= 1'b0;
      ser_clk_q <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      frame_q   <= load;
      ser_clk_q <= en_i && (bit_cnt_nxt < CNT_HALF);
    end
  end

  // Holding buffer; a same-cycle accept refills it as the old entry leaves
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= sym_i;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Sticky underflow flag and saturating insertion count; an insertion
  // coinciding with a clear still counts as one
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      underflow_q <= 1'b0;
      uf_cnt_q    <= '0;
    end else if (underflow_clr_i) begin
      underflow_q <= idle_ins;
      uf_cnt_q    <= {15'd0, idle_ins};
    end else if (idle_ins) begin
      underflow_q <= 1'b1;
      if (uf_cnt_q != 16'hFFFF)
        uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    video_ser_lane #(
      .SYM_W     (SYM_W),
      .LSB_FIRST (LSB_FIRST)
    ) u_lane (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .clear (lane_clear),
      .load  (load),
      .sym   (load_data[k*SYM_W +: SYM_W]),
      .ser   (ser_o[k])
    );
  end

endmodule

// File: tb/tb_video_serializer.sv
// Directed bench for video_serializer: a 3-lane 10-bit LSB-first instance
// and a 1-lane 8-bit MSB-first instance sharing clock and reset.
module tb_video_serializer;

  localparam logic [29:0] IDLE3  = {3{10'b1101010100}};
  localparam logic [7:0]  IDLE_B = 8'hD4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, valid, clr;
  logic [29:0] sym;
  logic        ready, ser_clk, frame, uf;
  logic [2:0]  ser;
  logic [15:0] uf_cnt;

  logic        en_b, valid_b, clr_b;
  logic [7:0]  sym_b;
  logic        ready_b, ser_clk_b, frame_b, uf_b;
  logic [0:0]  ser_b;
  logic [15:0] uf_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_serializer #(
    .CHANNELS(3), .SYM_W(10), .LSB_FIRST(1), .IDLE_SYM(10'b1101010100)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sym_i(sym),
    .sym_valid_i(valid), .sym_ready_o(ready), .ser_o(ser),
    .ser_clk_o(ser_clk), .frame_o(frame), .underflow_o(uf),
    .underflow_cnt_o(uf_cnt), .underflow_clr_i(clr)
  );

  video_serializer #(
    .CHANNELS(1), .SYM_W(8), .LSB_FIRST(0), .IDLE_SYM(IDLE_B)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .sym_i(sym_b),
    .sym_valid_i(valid_b), .sym_ready_o(ready_b), .ser_o(ser_b),
    .ser_clk_o(ser_clk_b), .frame_o(frame_b), .underflow_o(uf_b),
    .underflow_cnt_o(uf_cnt_b), .underflow_clr_i(clr_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [29:0] pat(input int n);
    logic [9:0] a, b, c;
    a = 10'(n * 37 + 5);
    b = 10'(n) ^ 10'h2B6;
    c = ~10'(n * 3);
    return {c, b, a};
  endfunction

  // Called at the negedge of the cycle that should carry bit 0
  task automatic check_symbol(input string tag, input logic [29:0] s);
    for (int i = 0; i < 10; i++) begin
      check_eq({tag, "_ser"}, 32'({s[20+i], s[10+i], s[i]}), 32'(ser));
      check_eq({tag, "_frame"}, 32'(frame), 32'(i == 0));
      check_eq({tag, "_serclk"}, 32'(ser_clk), 32'(i < 5));
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ser"}, 32'(ser), 32'd0);
    check_eq({tag, "_serclk"}, 32'(ser_clk), 32'd0);
    check_eq({tag, "_frame"}, 32'(frame), 32'd0);
  endtask

  initial begin
    logic [29:0] s1, sd, e;
    logic [7:0]  vb;
    int          s, i;
    logic [15:0] exp_cnt;

    rst_n = 1'b0; en = 1'b0; valid = 1'b0; clr = 1'b0; sym = '0;
    en_b = 1'b0; valid_b = 1'b0; clr_b = 1'b0; sym_b = '0;

    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'($urandom()); valid = 1'($urandom());
      clr = 1'($urandom()); sym = 30'($urandom());
      #1;
      check_quiet("rst");
      check_eq("rst_uf", 32'(uf), 32'd0);
      check_eq("rst_cnt", 32'(uf_cnt), 32'd0);
      check_eq("rst_ready", 32'(ready), 32'd1);
    end
    @(negedge clk);
    en = 1'b0; valid = 1'b0; clr = 1'b0; sym = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet("post_rst");
      check_eq("post_rst_ready", 32'(ready), 32'd1);
    end

    // Single symbol buffered while disabled, then enabled
    s1 = {10'h0F0, 10'h3C5, 10'b1010011100};
    sym = s1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check_eq("single_full_ready", 32'(ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check_symbol("single", s1);
    check_eq("idle1_cnt", 32'(uf_cnt), 32'd1);
    check_eq("idle1_uf", 32'(uf), 32'd1);
    check_symbol("idle1", IDLE3);

    // Reset in the middle of a symbol with a handshake pending
    repeat (3) @(negedge clk);
    valid = 1'b1; sym = pat(77);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet("midrst");
    check_eq("midrst_uf", 32'(uf), 32'd0);
    check_eq("midrst_cnt", 32'(uf_cnt), 32'd0);
    check_eq("midrst_ready", 32'(ready), 32'd1);
    valid = 1'b0; en = 1'b0;
    rst_n = 1'b1;

    // Streaming 100 symbols, then two idle insertions, clear on the third
    @(negedge clk);
    sym = pat(0); valid = 1'b1;
    @(negedge clk);
    sym = pat(1); en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 1030; c++) begin
      s = c / 10;
      i = c % 10;
      e = (s < 100) ? pat(s) : IDLE3;
      if (s < 100)       exp_cnt = 16'd0;
      else if (s == 100) exp_cnt = 16'd1;
      else if (s == 101) exp_cnt = 16'd2;
      else               exp_cnt = 16'd1;
      check_eq("strm_ser", 32'(ser), 32'({e[20+i], e[10+i], e[i]}));
      check_eq("strm_frame", 32'(frame), 32'(i == 0));
      check_eq("strm_serclk", 32'(ser_clk), 32'(i < 5));
      check_eq("strm_ready", 32'(ready), 32'((s >= 99) || (i == 9)));
      check_eq("strm_cnt", 32'(uf_cnt), 32'(exp_cnt));
      check_eq("strm_uf", 32'(uf), 32'(s >= 100));
      if (i == 0) begin
        clr = 1'b0;
        if (s + 2 < 100) sym = pat(s + 2);
        else             valid = 1'b0;
      end
      if (i == 9 && s == 101) clr = 1'b1;
      @(negedge clk);
    end
    check_eq("uf_cnt_after", 32'(uf_cnt), 32'd2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("clr_cnt", 32'(uf_cnt), 32'd0);
    check_eq("clr_uf", 32'(uf), 32'd0);

    // Disable mid-symbol with a symbol held in the buffer
    sd = pat(500);
    valid = 1'b1; sym = sd;
    @(negedge clk);
    valid = 1'b0;
    check_eq("dis_full_ready", 32'(ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("dis_bit4", 32'(ser), 32'({IDLE3[24], IDLE3[14], IDLE3[4]}));
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_quiet("dis");
      check_eq("dis_ready", 32'(ready), 32'd0);
      check_eq("dis_cnt", 32'(uf_cnt), 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    check_symbol("reen", sd);
    check_eq("reen_cnt", 32'(uf_cnt), 32'd1);
    en = 1'b0;

    // 8-bit MSB-first instance
    @(negedge clk);
    sym_b = 8'hA5; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0; en_b = 1'b1;
    @(negedge clk);
    vb = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      check_eq("b_ser", 32'(ser_b), 32'(vb[7-k]));
      check_eq("b_serclk", 32'(ser_clk_b), 32'(k < 4));
      check_eq("b_frame", 32'(frame_b), 32'(k == 0));
      @(negedge clk);
    end
    check_eq("b_cnt1", 32'(uf_cnt_b), 32'd1);
    check_eq("b_uf", 32'(uf_b), 32'd1);
    vb = IDLE_B;
    for (int k = 0; k < 8; k++) begin
      check_eq("b_idle_ser", 32'(ser_b), 32'(vb[7-k]));
      @(negedge clk);
    end
    check_eq("b_cnt2", 32'(uf_cnt_b), 32'd2);

    // Saturation: preload the counter close to the top, then keep underflowing
    force dut_b.uf_cnt_q = 16'hFFFD;
    repeat (10) @(negedge clk);
    release dut_b.uf_cnt_q;
    repeat (40) @(negedge clk);
    check_eq("b_sat1", 32'(uf_cnt_b), 32'h0000FFFF);
    repeat (16) @(negedge clk);
    check_eq("b_sat2", 32'(uf_cnt_b), 32'h0000FFFF);
    check_eq("b_sat_uf", 32'(uf_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
